// File: rtl/line_scanout_pkg.sv
// line_scanout_pkg
// Shared constants for the line-buffer scan-out block. These are the state
// encoding, the buffer word width, the bit-counter width and the default line
// geometry. The line_scanout top and its scanout_shifter sub-module import it.
package line_scanout_pkg;

  localparam int WORD_W             = 16;
  localparam int BIT_CNT_W          = 4;
  localparam int LINE_WORDS_DEFAULT = 160;
  localparam int ADDR_W_DEFAULT     = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/scanout_shifter.sv
// scanout_shifter
// A 16-bit pixel shift register. It has a parallel load, a left shift on
// enable, and an MSB output. When load and shift are both asserted in the
// same cycle, the load wins.
//
// Ports:
//   clk        - clock, posedge
//   rst        - asynchronous active-high reset
//   i_load     - load i_loadData into the register
//   i_loadData - parallel load value
//   i_shift    - shift left by one, filling with zero
//   o_msb      - current most-significant bit (the next pixel)
module scanout_shifter
  import line_scanout_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_loadData,
  input  logic              i_shift,
  output logic              o_msb
);

  logic [WORD_W-1:0] r_shreg;

  // Load has priority so that a word boundary can drop in the next word
  // on the same strobe that consumes the last bit of the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_loadData;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[WORD_W-1];

endmodule

// File: rtl/line_scanout.sv
// line_scanout
// This block is the read port of the 16-bit line buffer. On line_start it
// prefetches words 0 and 1. It then serializes the line MSB-first, emitting
// one pixel per pix_en. Each later word is fetched one word ahead, into a
// hold register.
//
// Optional feature: define LINE_SCANOUT_UNDERRUN_EN to implement the sticky
// underrun flag. When the macro is undefined, underrun is tied low and
// underrun_clr is ignored.
//
// Ports:
//   clk, rst      - clock (posedge) and asynchronous active-high reset
//   line_start    - single-cycle pulse; abort any line and start a new one
//   pix_en        - pixel strobe, one pixel consumed per high cycle
//   rd_en, raddr  - line-buffer read request (combinational)
//   rdata         - read data, valid the cycle after rd_en
//   pixel         - registered pixel value
//   pixel_valid   - pixel carries a line pixel this cycle
//   busy          - a line is in progress
//   underrun      - sticky: pix_en arrived with no pixel available
//   underrun_clr  - clears underrun (a simultaneous set wins)
module line_scanout
  import line_scanout_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic              pix_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] raddr,
  input  logic [WORD_W-1:0] rdata,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              busy,
  output logic              underrun,
  input  logic              underrun_clr
);

  // The word counter is one bit wider than the address so that a line of
  // exactly 2^ADDR_W words does not alias at the end.
  localparam logic [ADDR_W:0] WORDS     = (ADDR_W+1)'(LINE_WORDS);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(LINE_WORDS - 1);

  state_t                r_state;
  logic                  r_fillPhase;
  logic [ADDR_W:0]       r_wordIdx;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [WORD_W-1:0]     r_hold;
  logic                  r_holdCap;
  logic                  r_pixel;
  logic                  r_pixelValid;
  logic                  r_busy;

  logic                  w_fill;
  logic                  w_consume;
  logic                  w_wrap;
  logic                  w_lastWord;
  logic                  w_refill;
  logic [ADDR_W:0]       w_nextAddr;
  logic                  w_shLoad;
  logic [WORD_W-1:0]     w_loadData;
  logic                  w_shMsb;

  // A line_start in the current cycle overrides everything, so no read or
  // pixel work is started from the line being aborted.
  assign w_fill     = ~line_start & (r_state == ST_FILL);
  assign w_consume  = ~line_start & (r_state == ST_ACTIVE) & pix_en;
  assign w_wrap     = w_consume & (r_bitCnt == '1);
  assign w_lastWord = (r_wordIdx == LAST_WORD);
  assign w_nextAddr = r_wordIdx + (ADDR_W+1)'(2);
  assign w_refill   = w_wrap & (w_nextAddr < WORDS);

  // FILL reads word 0 and then word 1. During ACTIVE, each word boundary
  // fetches the word two ahead, which refills hold just after it is emptied.
  assign rd_en = w_fill | w_refill;
  assign raddr = w_fill   ? ADDR_W'(r_fillPhase) :
                 w_refill ? w_nextAddr[ADDR_W-1:0] : '0;

  // Word 0 goes straight from the buffer into the shifter. Every later word
  // passes through hold.
  assign w_shLoad   = (w_fill & r_fillPhase) | (w_wrap & ~w_lastWord);
  assign w_loadData = w_fill ? rdata : r_hold;

  scanout_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_shLoad),
    .i_loadData (w_loadData),
    .i_shift    (w_consume),
    .o_msb      (w_shMsb)
  );

  // Line sequencing: prefetch, pixel output, bit/word counting, and the
  // hold capture one cycle after each read that is not aimed at the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fillPhase  <= 1'b0;
      r_wordIdx    <= '0;
      r_bitCnt     <= '0;
      r_hold       <= '0;
      r_holdCap    <= 1'b0;
      r_pixel      <= 1'b0;
      r_pixelValid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy    <= line_start | (r_state != ST_IDLE);
      r_holdCap <= rd_en & ~(w_fill & ~r_fillPhase);
      if (r_holdCap) begin
        r_hold <= rdata;
      end
      if (line_start) begin
        r_state      <= ST_FILL;
        r_fillPhase  <= 1'b0;
        r_wordIdx    <= '0;
        r_bitCnt     <= '0;
        r_pixelValid <= 1'b0;
      end else begin
        case (r_state)
          ST_FILL: begin
            r_pixelValid <= 1'b0;
            if (pix_en) begin
              r_pixel <= 1'b0;
            end
            r_fillPhase <= 1'b1;
            if (r_fillPhase) begin
              r_state <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            r_pixelValid <= pix_en;
            if (pix_en) begin
              r_pixel  <= w_shMsb;
              r_bitCnt <= r_bitCnt + 1'b1;
              if (w_wrap) begin
                if (w_lastWord) begin
                  r_state <= ST_IDLE;
                end else begin
                  r_wordIdx <= r_wordIdx + 1'b1;
                end
              end
            end
          end
          default: begin
            r_pixelValid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign pixel       = r_pixel;
  assign pixel_valid = r_pixelValid;
  assign busy        = r_busy;

`ifdef LINE_SCANOUT_UNDERRUN_EN
  logic r_underrun;

  // Sticky underrun: pixels are only demanded while the prefetch is still
  // in flight. A new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_fill & pix_en) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun = r_underrun;
`else
  logic w_unusedClr;

  assign w_unusedClr = underrun_clr;
  assign underrun    = 1'b0;
`endif

endmodule

// File: tb/tb_line_scanout.sv
// tb_line_scanout
// Self-checking bench for line_scanout. A synchronous-RAM model serves reads
// and returns random junk when no read was issued. A line-level model derives
// the expected pixel stream, output timing and read requests from the line
// contents. A compare process checks every output on every falling edge.
// Hand-computed literal checks pin the model.
module tb_line_scanout;

  localparam int LW    = 160;
  localparam int AW    = 8;
  localparam int TOTAL = LW * 16;
`ifdef LINE_SCANOUT_UNDERRUN_EN
  localparam logic UEN = 1'b1;
`else
  localparam logic UEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lineStart = 1'b0;
  logic          pixEn = 1'b0;
  logic          underrunClr = 1'b0;
  logic [15:0]   rdata = 16'h0;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic          pixel;
  logic          pixel_valid;
  logic          busy;
  logic          underrun;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] mem [0:LW-1];

  line_scanout #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (lineStart),
    .pix_en       (pixEn),
    .rd_en        (rd_en),
    .raddr        (raddr),
    .rdata        (rdata),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_clr (underrunClr)
  );

  always #5 clk = ~clk;

  function void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Line buffer: the request is latched mid-cycle, and data appears the
  // following cycle. Cycles with no read return noise.
  logic          rdSeen = 1'b0;
  logic [AW-1:0] rdAddrSeen = '0;
  always @(negedge clk) begin
    rdSeen     <= rd_en;
    rdAddrSeen <= raddr;
  end
  always @(posedge clk) begin
    rdata <= rdSeen ? mem[rdAddrSeen] : 16'($urandom);
  end

  function automatic logic modelBit(input int p);
    logic [15:0] w;
    w = mem[p / 16];
    return w[15 - (p % 16)];
  endfunction

  // Line-level model. age counts cycles since the line_start edge (1 = the
  // first FILL cycle), and pos is the next line pixel to emit.
  logic inLine    = 1'b0;
  int   age       = 0;
  int   pos       = 0;
  logic expValid  = 1'b0;
  logic expPixel  = 1'b0;
  logic expBusy   = 1'b0;
  logic expUnder  = 1'b0;
  logic setU;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      inLine = 1'b0; age = 0; pos = 0;
      expValid = 1'b0; expPixel = 1'b0; expBusy = 1'b0; expUnder = 1'b0;
    end else begin
      setU = 1'b0;
      if (lineStart) begin
        inLine = 1'b1; age = 1; pos = 0; expValid = 1'b0; expBusy = 1'b1;
      end else if (inLine) begin
        expBusy = 1'b1;
        if (pixEn) begin
          if (age < 3) begin
            expValid = 1'b0; expPixel = 1'b0; setU = 1'b1;
          end else begin
            expValid = 1'b1; expPixel = modelBit(pos); pos++;
            if (pos == TOTAL) inLine = 1'b0;
          end
        end else begin
          expValid = 1'b0;
        end
        age++;
      end else begin
        expValid = 1'b0; expBusy = 1'b0;
      end
      if (UEN) begin
        if (setU) expUnder = 1'b1;
        else if (underrunClr) expUnder = 1'b0;
      end
    end
  end

  // Per-cycle comparison, plus line statistics used by the literal checks.
  int obsValid = 0, obsOnes = 0, firstOne = -1, obsReads = 0, lastRead = -1;
  logic          expRd;
  logic [AW-1:0] expAddr;

  always @(negedge clk) begin
    expRd = 1'b0; expAddr = '0;
    if (!rst && !lineStart && inLine) begin
      if (age <= 2) begin
        expRd = 1'b1; expAddr = AW'(age - 1);
      end else if (pixEn && (pos % 16) == 15 && (pos / 16 + 2) < LW) begin
        expRd = 1'b1; expAddr = AW'(pos / 16 + 2);
      end
    end
    checkOutput("rd_en", 32'(rd_en), 32'(expRd));
    if (expRd || rst) checkOutput("raddr", 32'(raddr), 32'(expAddr));
    checkOutput("pixel_valid", 32'(pixel_valid), 32'(expValid));
    checkOutput("pixel", 32'(pixel), 32'(expPixel));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("underrun", 32'(underrun), 32'(expUnder));
    if (rst || lineStart) begin
      obsValid = 0; obsOnes = 0; firstOne = -1; obsReads = 0; lastRead = -1;
    end else begin
      if (pixel_valid) begin
        if (pixel) begin
          if (firstOne < 0) firstOne = obsValid;
          obsOnes++;
        end
        obsValid++;
      end
      if (rd_en) begin
        obsReads++; lastRead = int'(raddr);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses line_start and returns in the first ACTIVE cycle (T+3).
  task automatic startLine();
    lineStart = 1'b1; pixEn = 1'b0;
    cycle();
    lineStart = 1'b0;
    cycle();
    cycle();
  endtask

  // Runs a whole line (mode 0: pix_en every cycle, 1: alternating) and checks
  // the first pixel and the busy drop one cycle after the final pixel.
  task automatic applyStimulus(input int mode, input logic expFirst);
    int   n;
    logic lastValid;
    logic dropped;
    n = 0; lastValid = 1'b0; dropped = 1'b0;
    startLine();
    pixEn = 1'b1;
    while (n < 8000 && !dropped) begin
      cycle(); n++;
      if (n == 1) begin
        checkOutput("first_pixel_valid", 32'(pixel_valid), 32'd1);
        checkOutput("first_pixel", 32'(pixel), 32'(expFirst));
      end
      if (!busy) dropped = 1'b1;
      else begin
        lastValid = pixel_valid;
        pixEn = (mode == 0) ? 1'b1 : ~pixEn;
      end
    end
    pixEn = 1'b0;
    checkOutput("line_completes", 32'(dropped), 32'd1);
    checkOutput("busy_drop_after_last_pixel", 32'(lastValid), 32'd1);
    checkOutput("pixel_count", 32'(obsValid), 32'(TOTAL));
  endtask

  initial begin
    for (int i = 0; i < LW; i++) mem[i] = 16'h8000;
    repeat (3) cycle();
    checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    rst = 1'b0;
    repeat (2) cycle();

    $display("[TB] line of 0x8000 words, pix_en continuous");
    applyStimulus(0, 1'b1);
    checkOutput("ones_count_8000", 32'(obsOnes), 32'd160);
    checkOutput("read_count_8000", 32'(obsReads), 32'd160);

    $display("[TB] single 1 in word 5 bit 0");
    for (int i = 0; i < LW; i++) mem[i] = 16'h0000;
    mem[5] = 16'h0001;
    repeat (2) cycle();
    applyStimulus(0, 1'b0);
    checkOutput("ones_count_word5", 32'(obsOnes), 32'd1);
    checkOutput("one_position", 32'(firstOne), 32'd95);

    $display("[TB] patterned line, pix_en alternating");
    for (int i = 0; i < LW; i++) mem[i] = 16'(i * 257) ^ 16'h5A3C;
    repeat (2) cycle();
    applyStimulus(1, 1'b0);
    checkOutput("read_count_alt", 32'(obsReads), 32'd160);
    checkOutput("last_read_addr", 32'(lastRead), 32'd159);

    $display("[TB] line_start abort at pixel 700");
    mem[0] = 16'hC000;
    startLine();
    pixEn = 1'b1;
    for (int n = 0; n < 3000 && obsValid < 700; n++) cycle();
    checkOutput("reached_pixel_700", 32'(obsValid), 32'd700);
    lineStart = 1'b1;
    cycle();
    lineStart = 1'b0; pixEn = 1'b0;
    cycle();
    cycle();
    pixEn = 1'b1;
    cycle();
    checkOutput("restart_pixel0_valid", 32'(pixel_valid), 32'd1);
    checkOutput("restart_pixel0", 32'(pixel), 32'd1);
    cycle();
    checkOutput("restart_pixel1", 32'(pixel), 32'd1);
    cycle();
    checkOutput("restart_pixel2", 32'(pixel), 32'd0);
    for (int n = 0; n < 3000 && busy; n++) cycle();
    pixEn = 1'b0;
    checkOutput("restart_pixel_count", 32'(obsValid), 32'(TOTAL));
    checkOutput("restart_read_count", 32'(obsReads), 32'd160);

    $display("[TB] underrun during FILL");
    cycle();
    lineStart = 1'b1;
    cycle();
    lineStart = 1'b0; pixEn = 1'b1;
    cycle();
    underrunClr = 1'b1;
    cycle();
    pixEn = 1'b0; underrunClr = 1'b0;
    checkOutput("underrun_set_wins", 32'(underrun), 32'(UEN));
    cycle();
    checkOutput("underrun_sticky", 32'(underrun), 32'(UEN));
    underrunClr = 1'b1;
    cycle();
    underrunClr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);

    $display("[TB] reset mid-line");
    pixEn = 1'b1;
    repeat (40) cycle();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("midreset_pixel", 32'(pixel), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rd_en", 32'(rd_en), 32'd0);
    checkOutput("midreset_raddr", 32'(raddr), 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    repeat (30) cycle();
    pixEn = 1'b0;
    checkOutput("no_reads_after_reset", 32'(obsReads), 32'd0);
    checkOutput("idle_after_reset", 32'(busy), 32'd0);

    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
